conv_ofmap_size_calc: RTL

Computes the output feature-map width and height of a convolution layer from its input size, padding, external (dilated) kernel size and stride. Each axis costs one request to the shared 16/3 multi-cycle divider; the block drives the divider's input stream and consumes its output stream. It runs once per layer configuration, ahead of the address-generation logic.

---
 rtl/conv_ofmap_size_calc_pkg.sv | 30 +++
 rtl/conv_ofmap_num_chk.sv | 18 +
 rtl/conv_ofmap_size_calc.sv | 122 ++++++++++++
 3 files changed

// File: rtl/conv_ofmap_size_calc_pkg.sv
// conv_ofmap_size_calc_pkg: field widths, divider packing, latched config and FSM states
package conv_ofmap_size_calc_pkg;
  localparam int IMG_W = 16;
  localparam int PAD_W = 3;
  localparam int STR_W = 3;
  localparam int KER_W = 8;
  localparam int NUM_W = 18;
  localparam int DIV_W = 24;
  localparam int DIV_DIVISOR_LSB = 16;
  typedef enum logic [2:0] {IDLE, CHK, REQ_W, WAIT_W, REQ_H, WAIT_H, DONE} state_e;
  typedef struct packed {
    logic [IMG_W-1:0] ifmap_w;
    logic [IMG_W-1:0] ifmap_h;
    logic [PAD_W-1:0] pad_l;
    logic [PAD_W-1:0] pad_r;
    logic [PAD_W-1:0] pad_t;
    logic [PAD_W-1:0] pad_b;
    logic [KER_W-1:0] ext_kw;
    logic [KER_W-1:0] ext_kh;
    logic [STR_W-1:0] stride_h;
    logic [STR_W-1:0] stride_v;
  } cfg_t;
  function automatic logic [DIV_W-1:0] div_pack(input logic [STR_W-1:0] divisor, input logic [IMG_W-1:0] dividend);
    logic [DIV_W-1:0] d;
    d = '0;
    d[DIV_DIVISOR_LSB +: STR_W] = divisor;
    d[IMG_W-1:0] = dividend;
    return d;
  endfunction
endpackage

// File: rtl/conv_ofmap_num_chk.sv
// conv_ofmap_num_chk: per-axis dividends of the output-size formula plus the illegal-config flag
//   cfg_i   latched layer configuration
//   num_w_o ifmap_w + pad_l + pad_r - ext_kw, 18-bit signed
//   num_h_o ifmap_h + pad_t + pad_b - ext_kh, 18-bit signed
//   err_o   a dividend outside 0..65535 or a zero stride
module conv_ofmap_num_chk
  import conv_ofmap_size_calc_pkg::*;
(
  input  cfg_t                    cfg_i,
  output logic signed [NUM_W-1:0] num_w_o,
  output logic signed [NUM_W-1:0] num_h_o,
  output logic                    err_o
);
  assign num_w_o = NUM_W'(cfg_i.ifmap_w) + NUM_W'(cfg_i.pad_l) + NUM_W'(cfg_i.pad_r) - NUM_W'(cfg_i.ext_kw);
  assign num_h_o = NUM_W'(cfg_i.ifmap_h) + NUM_W'(cfg_i.pad_t) + NUM_W'(cfg_i.pad_b) - NUM_W'(cfg_i.ext_kh);
  // bit 17 set means negative, bit 16 set (with 17 clear) means above 65535
  assign err_o = (|num_w_o[NUM_W-1:IMG_W]) | (|num_h_o[NUM_W-1:IMG_W]) | ~|cfg_i.stride_h | ~|cfg_i.stride_v;
endmodule

// File: rtl/conv_ofmap_size_calc.sv
// conv_ofmap_size_calc: output feature-map width/height via two requests to a shared divider
//   aclk/aresetn/aclken             clock, async active-low reset, clock enable
//   cfg_*  / cfg_valid/cfg_ready    layer configuration handshake
//   m_div_axis_*                    divider request {5'b0, divisor, dividend}
//   s_div_axis_*                    divider result  {rsv, remainder, quotient}
//   res_ofmap_w/h, res_err, res_*   result handshake; sizes read 0 when res_err
module conv_ofmap_size_calc
  import conv_ofmap_size_calc_pkg::*;
#(
  parameter int SIM_DELAY = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             aclken,
  input  logic [IMG_W-1:0] cfg_ifmap_w,
  input  logic [IMG_W-1:0] cfg_ifmap_h,
  input  logic [PAD_W-1:0] cfg_pad_l,
  input  logic [PAD_W-1:0] cfg_pad_r,
  input  logic [PAD_W-1:0] cfg_pad_t,
  input  logic [PAD_W-1:0] cfg_pad_b,
  input  logic [KER_W-1:0] cfg_ext_kw,
  input  logic [KER_W-1:0] cfg_ext_kh,
  input  logic [STR_W-1:0] cfg_stride_h,
  input  logic [STR_W-1:0] cfg_stride_v,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic [DIV_W-1:0] m_div_axis_data,
  output logic             m_div_axis_valid,
  input  logic             m_div_axis_ready,
  input  logic [DIV_W-1:0] s_div_axis_data,
  input  logic             s_div_axis_valid,
  output logic             s_div_axis_ready,
  output logic [IMG_W-1:0] res_ofmap_w,
  output logic [IMG_W-1:0] res_ofmap_h,
  output logic             res_err,
  output logic             res_valid,
  input  logic             res_ready
);
  state_e state_q, state_d;
  cfg_t cfg_q, cfg_d, cfg_in;
  logic [DIV_W-1:0] div_data_q, div_data_d;
  logic [IMG_W-1:0] res_w_q, res_w_d, res_h_q, res_h_d;
  logic err_q, err_d;
  logic signed [NUM_W-1:0] num_w, num_h;
  logic chk_err;
  logic [IMG_W:0] quot_inc;
  logic unused_sink;
  conv_ofmap_num_chk u_num_chk (
    .cfg_i   (cfg_q),
    .num_w_o (num_w),
    .num_h_o (num_h),
    .err_o   (chk_err)
  );
  assign cfg_in = {cfg_ifmap_w, cfg_ifmap_h, cfg_pad_l, cfg_pad_r, cfg_pad_t, cfg_pad_b,
                   cfg_ext_kw, cfg_ext_kh, cfg_stride_h, cfg_stride_v};
  assign cfg_ready        = aclken & (state_q == IDLE);
  assign m_div_axis_valid = aclken & ((state_q == REQ_W) | (state_q == REQ_H));
  assign s_div_axis_ready = aclken & ((state_q == WAIT_W) | (state_q == WAIT_H));
  assign res_valid        = aclken & (state_q == DONE);
  assign m_div_axis_data  = div_data_q;
  assign res_err          = err_q;
  assign res_ofmap_w      = err_q ? '0 : res_w_q;
  assign res_ofmap_h      = err_q ? '0 : res_h_q;
  // 17-bit sum so a quotient of 65535 turns into an overflow error instead of wrapping
  assign quot_inc = {1'b0, s_div_axis_data[IMG_W-1:0]} + (IMG_W+1)'(1);
  // remainder/reserved bits and the dividends' range bits are intentionally unused here;
  // SIM_DELAY is an interface-compatibility parameter, the RTL carries no delays
  assign unused_sink = ^{s_div_axis_data[DIV_W-1:IMG_W], num_w[NUM_W-1:IMG_W], num_h[NUM_W-1:IMG_W], SIM_DELAY[0]};
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    div_data_d = div_data_q;
    res_w_d    = res_w_q;
    res_h_d    = res_h_q;
    err_d      = err_q;
    case (state_q)
      IDLE: if (cfg_valid && cfg_ready) begin
        cfg_d   = cfg_in;
        res_w_d = '0;
        res_h_d = '0;
        err_d   = 1'b0;
        state_d = CHK;
      end
      CHK: begin
        err_d      = chk_err;
        div_data_d = chk_err ? div_data_q : div_pack(cfg_q.stride_h, num_w[IMG_W-1:0]);
        state_d    = chk_err ? DONE : REQ_W;
      end
      REQ_W: state_d = (m_div_axis_valid && m_div_axis_ready) ? WAIT_W : REQ_W;
      WAIT_W: if (s_div_axis_valid && s_div_axis_ready) begin
        res_w_d    = quot_inc[IMG_W-1:0];
        err_d      = err_q | quot_inc[IMG_W];
        div_data_d = div_pack(cfg_q.stride_v, num_h[IMG_W-1:0]);
        state_d    = REQ_H;
      end
      REQ_H: state_d = (m_div_axis_valid && m_div_axis_ready) ? WAIT_H : REQ_H;
      WAIT_H: if (s_div_axis_valid && s_div_axis_ready) begin
        res_h_d = quot_inc[IMG_W-1:0];
        err_d   = err_q | quot_inc[IMG_W];
        state_d = DONE;
      end
      DONE: state_d = (res_valid && res_ready) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      div_data_q <= '0;
      res_w_q    <= '0;
      res_h_q    <= '0;
      err_q      <= 1'b0;
    end else if (aclken) begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      div_data_q <= div_data_d;
      res_w_q    <= res_w_d;
      res_h_q    <= res_h_d;
      err_q      <= err_d;
    end
endmodule
